// File: rtl/multilane_link_monitor.sv
// -----------------------------------------------------------------------------
// multilane_link_monitor
//
// Watches a set of independent serial lanes. Every lane reports one frame per
// cycle at most (valid) along with a CRC verdict (crc_fail). Each lane runs a
// small UP/DOWN state machine with hysteresis:
//   - UP -> DOWN when a failing frame brings the consecutive-fail count to
//     FAILS_TO_DOWN, or brings the fail count of the current error-rate window
//     to WINDOW_FAIL_MAX.
//   - DOWN -> UP when a passing frame brings the consecutive-pass count to
//     PASSES_TO_UP.
// Per-lane statistics counters saturate instead of wrapping. The aggregate
// link is up while at least MIN_LANES_UP lanes are up.
//
// Ports
//   clk             sole clock
//   rst             synchronous active-high reset (all lanes UP, counters 0)
//   valid           [NUM_LANES]  per-lane frame present
//   crc_fail        [NUM_LANES]  per-lane CRC failure, qualified by valid
//   clear_stats     zero total_frames, total_crc_fails and down_count
//   lane_up         [NUM_LANES]  per-lane state (1 = UP)
//   link_up         aggregate state
//   lanes_up_count  number of lanes currently up
//   down_evt        [NUM_LANES]  one-cycle pulse on each UP->DOWN transition
//   total_frames, total_crc_fails, consec_fails, consec_passes, down_count
//                   [NUM_LANES*CNT_W]  lane i at bits [i*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module multilane_link_monitor #(
    parameter int NUM_LANES       = 4,
    parameter int CNT_W           = 32,
    parameter int FAILS_TO_DOWN   = 4,
    parameter int PASSES_TO_UP    = 8,
    parameter int WINDOW          = 64,
    parameter int WINDOW_FAIL_MAX = 8,
    parameter int MIN_LANES_UP    = NUM_LANES
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_LANES-1:0]             valid,
    input  logic [NUM_LANES-1:0]             crc_fail,
    input  logic                             clear_stats,
    output logic [NUM_LANES-1:0]             lane_up,
    output logic                             link_up,
    output logic [$clog2(NUM_LANES+1)-1:0]   lanes_up_count,
    output logic [NUM_LANES-1:0]             down_evt,
    output logic [NUM_LANES*CNT_W-1:0]       total_frames,
    output logic [NUM_LANES*CNT_W-1:0]       total_crc_fails,
    output logic [NUM_LANES*CNT_W-1:0]       consec_fails,
    output logic [NUM_LANES*CNT_W-1:0]       consec_passes,
    output logic [NUM_LANES*CNT_W-1:0]       down_count
);

    localparam int UPC_W    = $clog2(NUM_LANES + 1);
    // Window counters must hold both WINDOW and the fail threshold without
    // truncating either, independent of CNT_W.
    localparam int WIN_SPAN = (WINDOW > WINDOW_FAIL_MAX) ? WINDOW : WINDOW_FAIL_MAX;
    localparam int WIN_W    = $clog2(WIN_SPAN + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] F2D_TH    = CNT_W'(FAILS_TO_DOWN);
    localparam logic [CNT_W-1:0] P2U_TH    = CNT_W'(PASSES_TO_UP);
    localparam logic [WIN_W-1:0] WIN_LEN   = WIN_W'(WINDOW);
    localparam logic [WIN_W-1:0] WIN_FMAX  = WIN_W'(WINDOW_FAIL_MAX);
    localparam logic [WIN_W-1:0] WIN_ZERO  = {WIN_W{1'b0}};
    localparam logic [UPC_W-1:0] MIN_UP    = UPC_W'(MIN_LANES_UP);

    typedef enum logic {
        ST_UP   = 1'b0,
        ST_DOWN = 1'b1
    } lane_state_e;

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == CNT_MAX) begin
            sat_inc = value;
        end else begin
            sat_inc = value + CNT_W'(1);
        end
    endfunction

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            lane_state_e      state_r,       state_nxt_s;
            logic [CNT_W-1:0] frames_r,      frames_nxt_s;
            logic [CNT_W-1:0] fails_r,       fails_nxt_s;
            logic [CNT_W-1:0] cfail_r,       cfail_nxt_s;
            logic [CNT_W-1:0] cpass_r,       cpass_nxt_s;
            logic [CNT_W-1:0] downs_r,       downs_nxt_s;
            logic [WIN_W-1:0] win_frames_r,  win_frames_nxt_s;
            logic [WIN_W-1:0] win_fails_r,   win_fails_nxt_s;
            logic             down_evt_r,    down_evt_nxt_s;
            logic [CNT_W-1:0] cfail_inc_s;
            logic [CNT_W-1:0] cpass_inc_s;
            logic [WIN_W-1:0] win_frames_inc_s;
            logic [WIN_W-1:0] win_fails_inc_s;

            // Next-state and counter update for one lane; thresholds use the
            // post-increment values so the triggering frame itself counts.
            always_comb begin
                state_nxt_s      = state_r;
                frames_nxt_s     = frames_r;
                fails_nxt_s      = fails_r;
                cfail_nxt_s      = cfail_r;
                cpass_nxt_s      = cpass_r;
                downs_nxt_s      = downs_r;
                win_frames_nxt_s = win_frames_r;
                win_fails_nxt_s  = win_fails_r;
                down_evt_nxt_s   = 1'b0;

                cfail_inc_s      = sat_inc(cfail_r);
                cpass_inc_s      = sat_inc(cpass_r);
                // Window counts never reach WINDOW in a register, so +1 cannot wrap.
                win_frames_inc_s = win_frames_r + WIN_W'(1);
                win_fails_inc_s  = win_fails_r + WIN_W'(1);

                if (valid[g]) begin
                    frames_nxt_s = sat_inc(frames_r);

                    // The closing frame is part of the window's down check
                    // below, then both window counts restart from zero.
                    if (win_frames_inc_s == WIN_LEN) begin
                        win_frames_nxt_s = WIN_ZERO;
                        win_fails_nxt_s  = WIN_ZERO;
                    end else begin
                        win_frames_nxt_s = win_frames_inc_s;
                        win_fails_nxt_s  = crc_fail[g] ? win_fails_inc_s : win_fails_r;
                    end

                    if (crc_fail[g]) begin
                        fails_nxt_s = sat_inc(fails_r);
                        cfail_nxt_s = cfail_inc_s;
                        cpass_nxt_s = CNT_ZERO;
                        case (state_r)
                            ST_UP: begin
                                // Either rule (or both at once) gives one transition.
                                if ((cfail_inc_s >= F2D_TH) || (win_fails_inc_s >= WIN_FMAX)) begin
                                    state_nxt_s    = ST_DOWN;
                                    down_evt_nxt_s = 1'b1;
                                    downs_nxt_s    = sat_inc(downs_r);
                                end else begin
                                    state_nxt_s    = ST_UP;
                                end
                            end
                            ST_DOWN: state_nxt_s = ST_DOWN;
                            default: state_nxt_s = ST_UP;
                        endcase
                    end else begin
                        cpass_nxt_s = cpass_inc_s;
                        cfail_nxt_s = CNT_ZERO;
                        case (state_r)
                            ST_UP:   state_nxt_s = ST_UP;
                            ST_DOWN: begin
                                if (cpass_inc_s >= P2U_TH) begin
                                    state_nxt_s = ST_UP;
                                end else begin
                                    state_nxt_s = ST_DOWN;
                                end
                            end
                            default: state_nxt_s = ST_UP;
                        endcase
                    end
                end else begin
                    state_nxt_s = state_r;
                end

                // Clearing wins over any same-cycle increment of the totals.
                if (clear_stats) begin
                    frames_nxt_s = CNT_ZERO;
                    fails_nxt_s  = CNT_ZERO;
                    downs_nxt_s  = CNT_ZERO;
                end else begin
                    frames_nxt_s = frames_nxt_s;
                end
            end

            // Lane state and statistics registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_r      <= ST_UP;
                    frames_r     <= CNT_ZERO;
                    fails_r      <= CNT_ZERO;
                    cfail_r      <= CNT_ZERO;
                    cpass_r      <= CNT_ZERO;
                    downs_r      <= CNT_ZERO;
                    win_frames_r <= WIN_ZERO;
                    win_fails_r  <= WIN_ZERO;
                    down_evt_r   <= 1'b0;
                end else begin
                    state_r      <= state_nxt_s;
                    frames_r     <= frames_nxt_s;
                    fails_r      <= fails_nxt_s;
                    cfail_r      <= cfail_nxt_s;
                    cpass_r      <= cpass_nxt_s;
                    downs_r      <= downs_nxt_s;
                    win_frames_r <= win_frames_nxt_s;
                    win_fails_r  <= win_fails_nxt_s;
                    down_evt_r   <= down_evt_nxt_s;
                end
            end

            assign lane_up[g]                          = (state_r == ST_UP);
            assign down_evt[g]                         = down_evt_r;
            assign total_frames[g*CNT_W +: CNT_W]      = frames_r;
            assign total_crc_fails[g*CNT_W +: CNT_W]   = fails_r;
            assign consec_fails[g*CNT_W +: CNT_W]      = cfail_r;
            assign consec_passes[g*CNT_W +: CNT_W]     = cpass_r;
            assign down_count[g*CNT_W +: CNT_W]        = downs_r;
        end
    endgenerate

    // Popcount of the registered lane states; no added latency.
    always_comb begin
        lanes_up_count = {UPC_W{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            lanes_up_count = lanes_up_count + UPC_W'(lane_up[i]);
        end
    end

    assign link_up = (lanes_up_count >= MIN_UP);

endmodule

// File: tb/tb_multilane_link_monitor.sv
// -----------------------------------------------------------------------------
// Directed bench for multilane_link_monitor. Two instances share one clock:
//   dut_a - default parameters (4 lanes, 32-bit counters, all lanes required)
//   dut_b - CNT_W=4 (saturation) and MIN_LANES_UP=3 (aggregate threshold)
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_multilane_link_monitor;

    localparam int NL  = 4;
    localparam int CWA = 32;
    localparam int CWB = 4;

    logic clk;

    logic                rst_a, clr_a;
    logic [NL-1:0]       valid_a, fail_a;
    logic [NL-1:0]       lane_up_a, down_evt_a;
    logic                link_up_a;
    logic [2:0]          upcnt_a;
    logic [NL*CWA-1:0]   tf_a, tcf_a, cf_a, cp_a, dc_a;

    logic                rst_b, clr_b;
    logic [NL-1:0]       valid_b, fail_b;
    logic [NL-1:0]       lane_up_b, down_evt_b;
    logic                link_up_b;
    logic [2:0]          upcnt_b;
    logic [NL*CWB-1:0]   tf_b, tcf_b, cf_b, cp_b, dc_b;

    int n_checks = 0;
    int n_fail   = 0;

    multilane_link_monitor dut_a (
        .clk(clk), .rst(rst_a), .valid(valid_a), .crc_fail(fail_a), .clear_stats(clr_a),
        .lane_up(lane_up_a), .link_up(link_up_a), .lanes_up_count(upcnt_a),
        .down_evt(down_evt_a), .total_frames(tf_a), .total_crc_fails(tcf_a),
        .consec_fails(cf_a), .consec_passes(cp_a), .down_count(dc_a)
    );

    multilane_link_monitor #(.CNT_W(CWB), .MIN_LANES_UP(3)) dut_b (
        .clk(clk), .rst(rst_b), .valid(valid_b), .crc_fail(fail_b), .clear_stats(clr_b),
        .lane_up(lane_up_b), .link_up(link_up_b), .lanes_up_count(upcnt_b),
        .down_evt(down_evt_b), .total_frames(tf_b), .total_crc_fails(tcf_b),
        .consec_fails(cf_b), .consec_passes(cp_b), .down_count(dc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame cycle on dut_a, then inputs return to idle.
    task automatic fa(input logic [NL-1:0] v, input logic [NL-1:0] f);
        valid_a = v; fail_a = f;
        tick();
        valid_a = 4'h0; fail_a = 4'h0;
    endtask

    task automatic fb(input logic [NL-1:0] v, input logic [NL-1:0] f);
        valid_b = v; fail_b = f;
        tick();
        valid_b = 4'h0; fail_b = 4'h0;
    endtask

    initial begin
        rst_a = 1'b1; clr_a = 1'b0; valid_a = 4'h0; fail_a = 4'h0;
        rst_b = 1'b1; clr_b = 1'b0; valid_b = 4'h0; fail_b = 4'h0;
        tick(); tick();
        rst_a = 1'b0; rst_b = 1'b0;
        tick();

        // ---- reset state ----
        chk("rst_lane_up",  64'(lane_up_a), 64'hF);
        chk("rst_link_up",  64'(link_up_a), 64'h1);
        chk("rst_upcnt",    64'(upcnt_a),   64'h4);
        chk("rst_down_evt", 64'(down_evt_a), 64'h0);
        chk("rst_tf0",      64'(tf_a[0 +: CWA]), 64'h0);

        // ---- lane 0: four consecutive fails ----
        fa(4'h1, 4'h1); fa(4'h1, 4'h1); fa(4'h1, 4'h1);
        chk("l0_up_after3", 64'(lane_up_a), 64'hF);
        chk("l0_cf3",       64'(cf_a[0 +: CWA]), 64'h3);
        fa(4'h1, 4'h1);
        chk("l0_lane_up",   64'(lane_up_a), 64'hE);
        chk("l0_down_evt",  64'(down_evt_a), 64'h1);
        chk("l0_down_cnt",  64'(dc_a[0 +: CWA]), 64'h1);
        chk("l0_link_up",   64'(link_up_a), 64'h0);
        chk("l0_upcnt",     64'(upcnt_a), 64'h3);
        chk("l0_tcf",       64'(tcf_a[0 +: CWA]), 64'h4);
        fa(4'h0, 4'h0);
        chk("l0_evt_1cyc",  64'(down_evt_a), 64'h0);

        // ---- lane 1: down, then 7 pass / 1 fail / 8 pass ----
        for (int k = 0; k < 4; k++) fa(4'h2, 4'h2);
        chk("l1_down",      64'(lane_up_a), 64'hC);
        for (int k = 0; k < 7; k++) fa(4'h2, 4'h0);
        chk("l1_after7p",   64'(lane_up_a[1]), 64'h0);
        chk("l1_cp7",       64'(cp_a[CWA +: CWA]), 64'h7);
        fa(4'h2, 4'h2);
        chk("l1_cp_clr",    64'(cp_a[CWA +: CWA]), 64'h0);
        chk("l1_cf1",       64'(cf_a[CWA +: CWA]), 64'h1);
        for (int k = 1; k <= 8; k++) begin
            fa(4'h2, 4'h0);
            if (k == 7) chk("l1_after7p_b", 64'(lane_up_a[1]), 64'h0);
        end
        chk("l1_up",        64'(lane_up_a[1]), 64'h1);
        chk("l1_tf",        64'(tf_a[CWA +: CWA]), 64'd20);

        // ---- lane 2: 3 pass + 1 fail repeated; window rule at frame 32 ----
        for (int k = 1; k <= 32; k++) begin
            fa(4'h4, ((k % 4) == 0) ? 4'h4 : 4'h0);
            if (k == 31) chk("l2_up_f31", 64'(lane_up_a[2]), 64'h1);
        end
        chk("l2_down_f32",  64'(lane_up_a[2]), 64'h0);
        chk("l2_evt_f32",   64'(down_evt_a), 64'h4);
        chk("l2_cf_max1",   64'(cf_a[2*CWA +: CWA]), 64'h1);

        // ---- lane 3: partial window discarded by reset ----
        for (int k = 0; k < 7; k++) begin
            fa(4'h8, 4'h0);
            fa(4'h8, 4'h8);
        end
        chk("l3_up_pre",    64'(lane_up_a[3]), 64'h1);
        rst_a = 1'b1; valid_a = 4'h8; fail_a = 4'h8; clr_a = 1'b0;
        tick();
        rst_a = 1'b0; valid_a = 4'h0; fail_a = 4'h0;
        chk("rst2_lane_up", 64'(lane_up_a), 64'hF);
        chk("rst2_dc0",     64'(dc_a[0 +: CWA]), 64'h0);
        chk("rst2_tf3",     64'(tf_a[3*CWA +: CWA]), 64'h0);
        fa(4'h8, 4'h8);
        chk("l3_up_post",   64'(lane_up_a[3]), 64'h1);

        // ---- lane 2: 7 fails in frames 1-64, one more at 65 ----
        for (int k = 1; k <= 65; k++) begin
            fa(4'h4, (((k >= 10) && (((k - 10) % 9) == 0)) || (k == 65)) ? 4'h4 : 4'h0);
            if (k == 64) chk("l2_up_f64", 64'(lane_up_a[2]), 64'h1);
        end
        chk("l2_up_f65",    64'(lane_up_a[2]), 64'h1);
        chk("l2_cf_f65",    64'(cf_a[2*CWA +: CWA]), 64'h2);
        chk("l2_tcf_f65",   64'(tcf_a[2*CWA +: CWA]), 64'h8);
        chk("l2_tf_f65",    64'(tf_a[2*CWA +: CWA]), 64'd65);
        chk("l2_dc_f65",    64'(dc_a[2*CWA +: CWA]), 64'h0);

        // ---- lane 0: both down rules on the same frame ----
        for (int k = 0; k < 4; k++) begin
            fa(4'h1, 4'h1);
            fa(4'h1, 4'h0);
        end
        fa(4'h1, 4'h1); fa(4'h1, 4'h1); fa(4'h1, 4'h1);
        chk("both_up_pre",  64'(lane_up_a[0]), 64'h1);
        fa(4'h1, 4'h1);
        chk("both_down",    64'(lane_up_a[0]), 64'h0);
        chk("both_evt",     64'(down_evt_a), 64'h1);
        chk("both_dc",      64'(dc_a[0 +: CWA]), 64'h1);
        fa(4'h1, 4'h1);
        chk("both_evt_off", 64'(down_evt_a), 64'h0);
        chk("both_dc_hold", 64'(dc_a[0 +: CWA]), 64'h1);

        // ---- dut_b: saturation at CNT_W=4 ----
        for (int k = 1; k <= 20; k++) begin
            fb(4'h8, 4'h0);
            if (k == 15) chk("b_tf3_15", 64'(tf_b[3*CWB +: CWB]), 64'hF);
        end
        chk("b_tf3_sat",    64'(tf_b[3*CWB +: CWB]), 64'hF);
        chk("b_cp3_sat",    64'(cp_b[3*CWB +: CWB]), 64'hF);
        clr_b = 1'b1;
        fb(4'h8, 4'h0);
        clr_b = 1'b0;
        chk("b_clr_tf3",    64'(tf_b[3*CWB +: CWB]), 64'h0);
        chk("b_clr_cp3",    64'(cp_b[3*CWB +: CWB]), 64'hF);

        // ---- dut_b: MIN_LANES_UP=3 ----
        for (int k = 0; k < 4; k++) fb(4'h1, 4'h1);
        chk("b_one_down",   64'(lane_up_b), 64'hE);
        chk("b_link_1dn",   64'(link_up_b), 64'h1);
        chk("b_upcnt_1dn",  64'(upcnt_b), 64'h3);
        for (int k = 0; k < 3; k++) fb(4'h2, 4'h2);
        chk("b_link_pre",   64'(link_up_b), 64'h1);
        fb(4'h2, 4'h2);
        chk("b_two_down",   64'(lane_up_b), 64'hC);
        chk("b_link_2dn",   64'(link_up_b), 64'h0);
        chk("b_upcnt_2dn",  64'(upcnt_b), 64'h2);
        chk("b_evt_l1",     64'(down_evt_b), 64'h2);
        clr_b = 1'b1;
        fb(4'h0, 4'h0);
        clr_b = 1'b0;
        chk("b_clr_dc1",    64'(dc_b[CWB +: CWB]), 64'h0);
        chk("b_clr_state",  64'(lane_up_b), 64'hC);
        chk("b_clr_cf1",    64'(cf_b[CWB +: CWB]), 64'h4);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        chk("b_rst_lanes",  64'(lane_up_b), 64'hF);
        chk("b_rst_link",   64'(link_up_b), 64'h1);
        chk("b_rst_upcnt",  64'(upcnt_b), 64'h4);
        chk("b_rst_cf1",    64'(cf_b[CWB +: CWB]), 64'h0);
        chk("b_rst_tcf0",   64'(tcf_b[0 +: CWB]), 64'h0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
